// File: rtl/tt_ecp5_pkg.sv
// Shared types and constants for the ECP5 Tiny Tapeout multi-project mux.
package tt_ecp5_pkg;

    localparam int SYNC_STAGES         = 2;
    localparam int DEF_N_PROJECTS      = 4;
    localparam int DEF_RST_HOLD_CYCLES = 16;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        HOLD    = 2'd1,
        RUN     = 2'd2,
        INVALID = 2'd3
    } mux_state_e;

endpackage

// File: rtl/tt_ecp5_sync.sv
// Width-parametrised SYNC_STAGES-flop synchroniser with async active-low reset.
module tt_ecp5_sync
    import tt_ecp5_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    // NOTE: this array is a short flop chain, not a RAM, so resetting every entry is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep each stage reading the previous stage's old value.
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/tt_ecp5_mux.sv
// Multi-project mux core: selects one project at reset release, sequences its ena/reset
// and registers its outputs onto the shared pins. Optional TT_ECP5_SYNC_INPUTS_EN synchronises ui_in/uio_in.
module tt_ecp5_mux
    import tt_ecp5_pkg::*;
#(
    parameter int N_PROJECTS      = DEF_N_PROJECTS,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              ui_in,
    output logic [7:0]              uo_out,
    input  logic [7:0]              uio_in,
    output logic [7:0]              uio_out,
    output logic [7:0]              uio_oe,
    output logic [7:0]              proj_ui_in,
    output logic [7:0]              proj_uio_in,
    input  logic [8*N_PROJECTS-1:0] proj_uo_out,
    input  logic [8*N_PROJECTS-1:0] proj_uio_out,
    input  logic [8*N_PROJECTS-1:0] proj_uio_oe,
    output logic [N_PROJECTS-1:0]   proj_ena,
    output logic [N_PROJECTS-1:0]   proj_rst_n,
    output logic                    running,
    output logic                    sel_err
);

    localparam int SEL_W = (N_PROJECTS > 1) ? $clog2(N_PROJECTS) : 1;
    localparam int CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    logic             rst_sync;
    logic [7:0]       ui_in_s;
    logic [7:0]       uio_in_s;
    mux_state_e       state;
    mux_state_e       state_nxt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_d;
    logic             sel_ok;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       slice_uo;
    logic [7:0]       slice_uio;
    logic [7:0]       slice_oe;

    // Asserts with rst_n immediately, releases two edges later.
    tt_ecp5_sync #(.WIDTH(1)) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (1'b1),
        .q     (rst_sync)
    );

`ifdef TT_ECP5_SYNC_INPUTS_EN
    tt_ecp5_sync #(.WIDTH(8)) u_ui_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (ui_in_s)
    );

    tt_ecp5_sync #(.WIDTH(8)) u_uio_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uio_in),
        .q     (uio_in_s)
    );
`else
    assign ui_in_s  = ui_in;
    assign uio_in_s = uio_in;
`endif

    assign proj_ui_in  = ui_in_s;
    assign proj_uio_in = uio_in_s;

    assign sel_d  = ui_in_s[SEL_W-1:0];
    assign sel_ok = ({1'b0, sel_d} < (SEL_W+1)'(N_PROJECTS));

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: defaulting every comb output first is what prevents latch inference.
        state_nxt = state;
        unique case (state)
            RESET:   state_nxt = sel_ok ? HOLD : INVALID;
            HOLD:    if (cnt == CNT_LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            INVALID: state_nxt = INVALID;
            default: state_nxt = RESET;
        endcase
    end

    // sel is only written while in RESET, so later ui_in changes never reselect.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            sel <= '0;
            cnt <= '0;
        end else begin
            if (state == RESET) sel <= sel_d;
            if (state == HOLD && cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        proj_ena   = '0;
        proj_rst_n = '0;
        slice_uo   = '0;
        slice_uio  = '0;
        slice_oe   = '0;
        for (int p = 0; p < N_PROJECTS; p++) begin
            if (sel == SEL_W'(p)) begin
                proj_ena[p]   = (state == HOLD) || (state == RUN);
                proj_rst_n[p] = (state == RUN);
                slice_uo      = proj_uo_out[8*p +: 8];
                slice_uio     = proj_uio_out[8*p +: 8];
                slice_oe      = proj_uio_oe[8*p +: 8];
            end
        end
    end

    assign running = (state == RUN);
    assign sel_err = (state == INVALID);

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else if (state == RUN) begin
            uo_out  <= slice_uo;
            uio_out <= slice_uio;
            uio_oe  <= slice_oe;
        end else begin
            uo_out  <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
        end
    end

endmodule

// File: tb/tb_tt_ecp5_mux.sv
// Self-checking bench: three mux instances (4/16, 3/4, 1/1) against an edge-count reference model.
module tb_tt_ecp5_mux;

    localparam int HOLD_A = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_a = 8'h02;
    logic [7:0]  ui_b = 8'h03;
    logic [7:0]  ui_c = 8'h01;
    logic [7:0]  uio_in = 8'h00;
    logic [31:0] pu_a = '0;
    logic [31:0] puio_a = '0;
    logic [31:0] poe_a = '0;

    logic [7:0] uo_a, uio_a, oe_a, pui_a, puio_in_a;
    logic [3:0] ena_a, prst_a;
    logic       run_a, err_a;
    logic [7:0] uo_b, uio_b, oe_b, pui_b, puio_in_b;
    logic [2:0] ena_b, prst_b;
    logic       run_b, err_b;
    logic [7:0] uo_c, uio_c, oe_c, pui_c, puio_in_c;
    logic [0:0] ena_c, prst_c;
    logic       run_c, err_c;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tt_ecp5_mux #(.N_PROJECTS(4), .RST_HOLD_CYCLES(HOLD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_a), .uo_out(uo_a), .uio_in(uio_in),
        .uio_out(uio_a), .uio_oe(oe_a), .proj_ui_in(pui_a), .proj_uio_in(puio_in_a),
        .proj_uo_out(pu_a), .proj_uio_out(puio_a), .proj_uio_oe(poe_a),
        .proj_ena(ena_a), .proj_rst_n(prst_a), .running(run_a), .sel_err(err_a)
    );

    tt_ecp5_mux #(.N_PROJECTS(3), .RST_HOLD_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_b), .uo_out(uo_b), .uio_in(uio_in),
        .uio_out(uio_b), .uio_oe(oe_b), .proj_ui_in(pui_b), .proj_uio_in(puio_in_b),
        .proj_uo_out(pu_a[23:0]), .proj_uio_out(puio_a[23:0]), .proj_uio_oe(poe_a[23:0]),
        .proj_ena(ena_b), .proj_rst_n(prst_b), .running(run_b), .sel_err(err_b)
    );

    tt_ecp5_mux #(.N_PROJECTS(1), .RST_HOLD_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_c), .uo_out(uo_c), .uio_in(uio_in),
        .uio_out(uio_c), .uio_oe(oe_c), .proj_ui_in(pui_c), .proj_uio_in(puio_in_c),
        .proj_uo_out(pu_a[7:0]), .proj_uio_out(puio_a[7:0]), .proj_uio_oe(poe_a[7:0]),
        .proj_ena(ena_c), .proj_rst_n(prst_c), .running(run_c), .sel_err(err_c)
    );

    // Reference model: e counts rising edges since release, so edge En has just happened when e == n.
    int unsigned e;
    logic [1:0]  a_sel;
    logic        c_bit;
    logic [7:0]  ea_uo, ea_uio, ea_oe, ec_uo, ec_uio, ec_oe;
    logic [7:0]  ui_d1, ui_d2, uio_d1, uio_d2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e      <= 0;
            ea_uo  <= '0; ea_uio <= '0; ea_oe <= '0;
            ec_uo  <= '0; ec_uio <= '0; ec_oe <= '0;
            ui_d1  <= '0; ui_d2  <= '0; uio_d1 <= '0; uio_d2 <= '0;
        end else begin
            e <= e + 1;
            if (e == 2) begin
                a_sel <= ui_a[1:0];
                c_bit <= ui_c[0];
            end
            // A project drives the pins one edge after it is seen running.
            ea_uo  <= (e >= 3 + HOLD_A) ? pu_a[a_sel*8 +: 8]   : 8'h00;
            ea_uio <= (e >= 3 + HOLD_A) ? puio_a[a_sel*8 +: 8] : 8'h00;
            ea_oe  <= (e >= 3 + HOLD_A) ? poe_a[a_sel*8 +: 8]  : 8'h00;
            ec_uo  <= (!c_bit && e >= 4) ? pu_a[7:0]   : 8'h00;
            ec_uio <= (!c_bit && e >= 4) ? puio_a[7:0] : 8'h00;
            ec_oe  <= (!c_bit && e >= 4) ? poe_a[7:0]  : 8'h00;
            ui_d1  <= ui_a;  ui_d2  <= ui_d1;
            uio_d1 <= uio_in; uio_d2 <= uio_d1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data(input bit fix_a5, input bit fix_s1);
        pu_a   = $urandom;
        puio_a = $urandom;
        poe_a  = $urandom;
        uio_in = 8'($urandom);
        if (fix_a5) pu_a[23:16] = 8'hA5;
        if (fix_s1) begin
            poe_a[15:8]  = 8'hF0;
            puio_a[15:8] = 8'h3C;
            uio_in       = 8'h5A;
        end
    endtask

    task automatic check_all();
        logic [3:0] xa_ena;
        logic [3:0] xa_rst;
        bit         c_ok;
        xa_ena = (e >= 3) ? 4'(1 << a_sel) : 4'b0000;
        xa_rst = (e >= 3 + HOLD_A) ? 4'(1 << a_sel) : 4'b0000;
        check("a_uo_out", uo_a, ea_uo);
        check("a_uio_out", uio_a, ea_uio);
        check("a_uio_oe", oe_a, ea_oe);
        check("a_proj_ena", ena_a, xa_ena);
        check("a_proj_rst_n", prst_a, xa_rst);
        check("a_running", run_a, e >= 3 + HOLD_A);
        check("a_sel_err", err_a, 0);
`ifdef TT_ECP5_SYNC_INPUTS_EN
        check("a_proj_ui_in", pui_a, ui_d2);
        check("a_proj_uio_in", puio_in_a, uio_d2);
`else
        check("a_proj_ui_in", pui_a, ui_a);
        check("a_proj_uio_in", puio_in_a, uio_in);
`endif
        check("b_sel_err", err_b, e >= 3);
        check("b_proj_ena", ena_b, 0);
        check("b_uo_out", uo_b, 0);
        check("b_uio_oe", oe_b, 0);
        c_ok = (e >= 3) && !c_bit;
        check("c_sel_err", err_c, (e >= 3) && c_bit);
        check("c_proj_ena", ena_c, c_ok);
        check("c_running", run_c, c_ok && e >= 4);
        check("c_proj_rst_n", prst_c, c_ok && e >= 4);
        check("c_uo_out", uo_c, ec_uo);
        check("c_uio_out", uio_c, ec_uio);
        check("c_uio_oe", oe_c, ec_oe);
    endtask

    task automatic step(input bit fix_a5, input bit fix_s1);
        @(posedge clk);
        @(negedge clk);
        check_all();
        drive_data(fix_a5, fix_s1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_uo"}, uo_a, 0);
        check({tag, "_uio"}, uio_a, 0);
        check({tag, "_oe"}, oe_a, 0);
        check({tag, "_ena"}, ena_a, 0);
        check({tag, "_rst_n"}, prst_a, 0);
        check({tag, "_running"}, run_a, 0);
        check({tag, "_b_sel_err"}, err_b, 0);
        check({tag, "_c_ena"}, ena_c, 0);
        check({tag, "_c_sel_err"}, err_c, 0);
    endtask

    // Asserts rst_n mid-cycle, checks the async clear, then releases on a falling edge.
    task automatic do_reset(input logic [7:0] ua, input logic [7:0] uc);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        ui_a = ua;
        ui_c = uc;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Select project 2 with the full 16-cycle hold; slice 2 is pinned to A5.
        drive_data(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0);
            if (e == 3)  check("sel2_ena_e3", ena_a, 4'b0100);
            if (e == 18) check("sel2_rst_e18", prst_a, 4'b0000);
            if (e == 19) check("sel2_rst_e19", prst_a, 4'b0100);
            if (e == 19) check("sel2_uo_e19", uo_a, 8'h00);
            if (e == 20) check("sel2_uo_e20", uo_a, 8'hA5);
        end

        // Select project 1, then try to reselect project 3 while running.
        do_reset(8'h01, 8'h00);
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1);
            if (e == 21) check("s1_oe_e21", oe_a, 8'hF0);
            if (e == 21) check("s1_uio_e21", uio_a, 8'h3C);
        end
        ui_a = 8'h03;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("reselect_ena", ena_a, 4'b0010);

        // Mid-run reset back to project 0.
        do_reset(8'h00, 8'h01);
        for (int i = 0; i < 22; i++) begin
            step(1'b0, 1'b0);
            if (e == 18) check("p0_running_e18", run_a, 1'b0);
            if (e == 19) check("p0_running_e19", run_a, 1'b1);
        end

        // Randomised selections for the 4-project and 1-project instances.
        for (int r = 0; r < 4; r++) begin
            do_reset(8'($urandom), {7'($urandom), 1'(r)});
            for (int i = 0; i < 22 + r; i++) step(1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
